conv_result_packer: RTL and testbench
=====================================

# conv_result_packer

Downstream of the convolution unit: accepts 144-bit convolution result beats (18 output channels × 8 bit) and repacks them, bit-contiguously, into 256-bit words for the DDR write path. It has a valid/ready handshake on both sides, a layer-end flush that zero-pads the last partial word, and a count of emitted words for the write-address sequencer.

## Interface

Parameters:
- IN_WIDTH, 144, input beat width (CONV_OUT_NUM × DATA_WIDTH)
- OUT_WIDTH, 256, DDR word width
- CNT_WIDTH, 16, width of the emitted-word counter

Ports:
- clk  in  1  single clock; all logic on its rising edge
- rst  in  1  asynchronous, active-high reset
- Conv_data_in  in  144  result beat
- Conv_data_valid_in  in  1  beat valid
- Conv_ready_out  out  1  packer can accept a beat this cycle
- flush_in  in  1  single-cycle pulse marking end of layer
- DDR_data_out  out  256  packed word
- DDR_valid_out  out  1  word valid; held until accepted
- DDR_ready_in  in  1  DDR write path accepts the word
- flush_done  out  1  single-cycle pulse when the flush completes
- word_cnt  out  16  words handed over since reset or since the last flush_done

## Operation

Internal state:
- Accumulator buf[399:0].
- Fill count fill (0..399).
- Output register {DDR_data_out, DDR_valid_out}.
- FSM states RUN and FLUSH.

Stream order:
- Stream bit k of the sequence of accepted beats maps to DDR word n = k/256, bit k mod 256.
- The first beat occupies bits [143:0] of word 0.

Definitions:
- load: the output register is free (!DDR_valid_out || DDR_ready_in) and either fill ≥ 256 (RUN), or fill > 0 (FLUSH).
- On load, DDR_data_out ← buf[255:0], with bits at or above fill zeroed when fill < 256. Then buf shifts right by 256 and fill ← max(fill − 256, 0).

Acceptance:
- Conv_ready_out = (state == RUN) && (fill < 256 || load). It is combinational on DDR_ready_in.
- On accept, the beat is written at buf[fill +: 144] after any same-cycle shift.
- Next fill is fill − 256·load + 144. The maximum is 399, so the accumulator never overflows.

FSM:
- RUN → FLUSH on flush_in. A beat accepted in the same cycle belongs to the layer being flushed.
- In FLUSH, Conv_ready_out = 0. Loads continue, zero-padded, until fill == 0 and the output register is empty or being accepted this cycle.
- At that point flush_done pulses for 1 cycle, word_cnt clears, and state → RUN.
- flush_in with fill == 0 and the output register empty completes in the next cycle: flush_done pulses and no word is emitted.
- flush_in while in FLUSH is ignored.

word_cnt:
- Increments on each DDR handshake (DDR_valid_out && DDR_ready_in).
- Wraps at 2^16.
- A clear on flush_done overrides a same-cycle increment.

Upstream protocol:
- Upstream holds Conv_data_in stable while Conv_data_valid_in && !Conv_ready_out.
- A beat is consumed only on valid && ready.

## Timing

- Reset (async, immediate) sets:
  - fill = 0
  - buf = 0
  - DDR_data_out = 0
  - DDR_valid_out = 0
  - flush_done = 0
  - word_cnt = 0
  - state = RUN
  - Conv_ready_out = 1 once rst deasserts
- Latency: beats accepted in cycles 0 and 1 give fill = 288 in cycle 2. The load occurs at the end of cycle 2, and DDR_valid_out = 1 in cycle 3.
- Throughput: with DDR_ready_in = 1, one beat is accepted every cycle indefinitely. 16 beats produce exactly 9 words, and fill returns to 0.
- Backpressure:
  - While DDR_ready_in = 0 with DDR_valid_out = 1, DDR_data_out is held stable.
  - Beats are accepted only while fill < 256. At most 2 further beats are accepted after the stall begins.
- Flush: the number of extra words is ceil(fill / 256), issued one per cycle while DDR_ready_in = 1. flush_done pulses in the cycle after the last handshake.
- Reset mid-operation discards buffered data and any pending word.

## Test plan

- Sustained stream: 16 beats, where beat i has every byte = i, with DDR_ready_in = 1 → 9 words.
  - Word 0 = {beat1[111:0], beat0}.
  - Word 8 ends with beat15 in bits [255:112].
  - Conv_ready_out never drops; word_cnt = 9.
- Backpressure: DDR_ready_in = 0 for 10 cycles mid-stream → DDR_data_out stable, Conv_ready_out low once fill ≥ 256, no beat lost or duplicated; output matches a golden bit-stream model.
- Flush with partial data: 3 beats (432 bits) then flush_in → word 0 full; word 1 carries bits [175:0] valid and [255:176] = 0; flush_done after the second handshake; word_cnt = 0 afterwards.
- Empty flush: flush_in at fill = 0 → flush_done one cycle later, DDR_valid_out never asserted.
- Flush coincident with a beat: beat accepted in the same cycle as flush_in is included in the padded output; ready low during FLUSH.
- Async reset asserted mid-word with DDR_valid_out = 1 → all outputs zero immediately; a subsequent stream restarts packing at bit 0.

Source files
------------

// File: rtl/conv_result_packer_if.sv
// Conv-result / DDR-word bundle for the packer: beat stream in, packed words out, flush and count.
// The packer takes the slave view; the producer/consumer side takes the master view.
interface conv_result_packer_if #(
    parameter int IN_WIDTH  = 144,
    parameter int OUT_WIDTH = 256,
    parameter int CNT_WIDTH = 16
);
    logic [IN_WIDTH-1:0]  Conv_data_in;
    logic                 Conv_data_valid_in;
    logic                 Conv_ready_out;
    logic                 flush_in;
    logic [OUT_WIDTH-1:0] DDR_data_out;
    logic                 DDR_valid_out;
    logic                 DDR_ready_in;
    logic                 flush_done;
    logic [CNT_WIDTH-1:0] word_cnt;

    modport slave (
        input  Conv_data_in, Conv_data_valid_in, flush_in, DDR_ready_in,
        output Conv_ready_out, DDR_data_out, DDR_valid_out, flush_done, word_cnt
    );

    modport master (
        output Conv_data_in, Conv_data_valid_in, flush_in, DDR_ready_in,
        input  Conv_ready_out, DDR_data_out, DDR_valid_out, flush_done, word_cnt
    );
endinterface

// File: rtl/conv_result_packer.sv
// Repacks 144-bit conv beats bit-contiguously into 256-bit DDR words; first word valid 3 cycles after the first beat.
// Backpressure: output word held while DDR_ready_in is low; beats refused once 256+ bits are buffered or during flush.
module conv_result_packer #(
    parameter int IN_WIDTH  = 144,
    parameter int OUT_WIDTH = 256,
    parameter int CNT_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    conv_result_packer_if.slave     io_bus
);
    localparam int BUF_W  = IN_WIDTH + OUT_WIDTH;
    localparam int FILL_W = $clog2(BUF_W + 1);
    localparam logic [FILL_W-1:0] OUT_W_F = FILL_W'(OUT_WIDTH);
    localparam logic [FILL_W-1:0] IN_W_F  = FILL_W'(IN_WIDTH);

    typedef enum logic {S_RUN = 1'b0, S_FLUSH = 1'b1} state_t;

    state_t                r_state, w_state_nxt;
    logic [BUF_W-1:0]      r_buf, w_buf_nxt, w_buf_shifted;
    logic [FILL_W-1:0]     r_fill, w_fill_nxt, w_fill_shifted;
    logic [OUT_WIDTH-1:0]  r_ddr_dat, w_ddr_dat_nxt, w_mask;
    logic                  r_ddr_vld, w_ddr_vld_nxt;
    logic                  r_flush_done, w_flush_done_nxt;
    logic [CNT_WIDTH-1:0]  r_word_cnt, w_word_cnt_nxt;
    logic                  w_out_free, w_load, w_ready, w_accept, w_ddr_hs, w_done;

    // Handshake and load decisions; ready looks through a same-cycle load.
    always_comb begin
        w_out_free = !r_ddr_vld || io_bus.DDR_ready_in;
        w_load     = w_out_free && ((r_state == S_RUN) ? (r_fill >= OUT_W_F) : (r_fill != '0));
        w_ready    = (r_state == S_RUN) && ((r_fill < OUT_W_F) || w_load);
        w_accept   = io_bus.Conv_data_valid_in && w_ready;
        w_ddr_hs   = r_ddr_vld && io_bus.DDR_ready_in;
        w_done     = (r_state == S_FLUSH) && (r_fill == '0) && w_out_free;
    end

    always_comb begin
        w_mask         = (r_fill >= OUT_W_F) ? {OUT_WIDTH{1'b1}} : ~({OUT_WIDTH{1'b1}} << r_fill);
        w_buf_shifted  = r_buf;
        w_fill_shifted = r_fill;
        if (w_load) begin
            w_buf_shifted  = r_buf >> OUT_WIDTH;
            w_fill_shifted = (r_fill >= OUT_W_F) ? (r_fill - OUT_W_F) : '0;
        end
        // New beat lands just above whatever survives the shift.
        w_buf_nxt  = w_buf_shifted;
        w_fill_nxt = w_fill_shifted;
        if (w_accept) begin
            w_buf_nxt  = w_buf_shifted | (BUF_W'(io_bus.Conv_data_in) << w_fill_shifted);
            w_fill_nxt = w_fill_shifted + IN_W_F;
        end
    end

    always_comb begin
        w_ddr_dat_nxt = r_ddr_dat;
        w_ddr_vld_nxt = r_ddr_vld;
        if (w_load) begin
            w_ddr_dat_nxt = r_buf[OUT_WIDTH-1:0] & w_mask;
            w_ddr_vld_nxt = 1'b1;
        end else if (io_bus.DDR_ready_in) begin
            w_ddr_vld_nxt = 1'b0;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_flush_done_nxt = 1'b0;
        w_word_cnt_nxt   = r_word_cnt;
        case (r_state)
            S_RUN: begin
                if (io_bus.flush_in) begin
                    w_state_nxt = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (w_done) begin
                    w_state_nxt      = S_RUN;
                    w_flush_done_nxt = 1'b1;
                end
            end
            default: w_state_nxt = S_RUN;
        endcase
        if (w_done) begin
            w_word_cnt_nxt = '0;
        end else if (w_ddr_hs) begin
            w_word_cnt_nxt = r_word_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_RUN;
            r_buf        <= '0;
            r_fill       <= '0;
            r_ddr_dat    <= '0;
            r_ddr_vld    <= 1'b0;
            r_flush_done <= 1'b0;
            r_word_cnt   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_buf        <= w_buf_nxt;
            r_fill       <= w_fill_nxt;
            r_ddr_dat    <= w_ddr_dat_nxt;
            r_ddr_vld    <= w_ddr_vld_nxt;
            r_flush_done <= w_flush_done_nxt;
            r_word_cnt   <= w_word_cnt_nxt;
        end
    end

    assign io_bus.Conv_ready_out = w_ready;
    assign io_bus.DDR_data_out   = r_ddr_dat;
    assign io_bus.DDR_valid_out  = r_ddr_vld;
    assign io_bus.flush_done     = r_flush_done;
    assign io_bus.word_cnt       = r_word_cnt;

endmodule

// File: tb/tb_conv_result_packer.sv
// Directed + randomized bench for conv_result_packer against a bit-queue stream model.
module tb_conv_result_packer;
    localparam int IW = 144;
    localparam int OW = 256;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    conv_result_packer_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .CNT_WIDTH(CW)) bus ();

    conv_result_packer #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .CNT_WIDTH(CW)) dut (
        .clk    (clk),
        .rst    (rst),
        .io_bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    bit            model_q[$];
    logic [OW-1:0] got_words[$];
    int            model_cnt    = 0;
    bit            flush_pend   = 0;
    int            flush_seen   = 0;
    int            stall_cycles = 0;
    int            vld_cycles   = 0;
    int            ddr_mode     = 0;  // 0: always ready, 1: random, 2: stalled

    task automatic chk(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        case (ddr_mode)
            0:       bus.DDR_ready_in = 1'b1;
            1:       bus.DDR_ready_in = 1'($urandom_range(0, 1));
            default: bus.DDR_ready_in = 1'b0;
        endcase
    end

    // Stream model: every accepted beat appends 144 bits; every handshake removes the next 256.
    always @(negedge clk) begin
        logic [OW-1:0] exp_w;
        int            n;
        if (!rst) begin
            if (bus.flush_done) begin
                flush_seen++;
                flush_pend = 0;
                model_cnt  = 0;
            end
            if (bus.DDR_valid_out) vld_cycles++;
            if (bus.DDR_valid_out && bus.DDR_ready_in) begin
                exp_w = '0;
                n = (model_q.size() < OW) ? model_q.size() : OW;
                if (n < OW) chk("partial_word_only_in_flush", OW'(flush_pend), OW'(1));
                for (int i = 0; i < n; i++) exp_w[i] = model_q.pop_front();
                chk("ddr_word", bus.DDR_data_out, exp_w);
                got_words.push_back(bus.DDR_data_out);
                model_cnt++;
            end
            if (bus.Conv_data_valid_in && bus.Conv_ready_out) begin
                for (int i = 0; i < IW; i++) model_q.push_back(bus.Conv_data_in[i]);
            end
            if (bus.Conv_data_valid_in && !bus.Conv_ready_out) stall_cycles++;
        end
    end

    function automatic logic [IW-1:0] pat(input int b);
        logic [7:0] bb;
        bb = b[7:0];
        return {18{bb}};
    endfunction

    function automatic logic [IW-1:0] rnd_beat();
        logic [159:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return r[IW-1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [IW-1:0] d);
        int t;
        t = 0;
        bus.Conv_data_in       = d;
        bus.Conv_data_valid_in = 1'b1;
        @(negedge clk);
        while (!bus.Conv_ready_out && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) chk("beat_accept_timeout", OW'(bus.Conv_ready_out), OW'(1));
        @(posedge clk);
        #1;
        bus.Conv_data_valid_in = 1'b0;
    endtask

    task automatic pulse_flush();
        bus.flush_in = 1'b1;
        flush_pend   = 1;
        tick();
        bus.flush_in = 1'b0;
    endtask

    task automatic wait_flush(input string tag, output int lat);
        int start;
        start = flush_seen;
        lat   = 0;
        while (flush_seen == start && lat < 200) begin
            @(negedge clk);
            #1;
            lat++;
        end
        chk(tag, OW'(flush_seen > start), OW'(1));
        tick();
    endtask

    initial begin
        int            lat;
        int            vld0;
        logic [OW-1:0] w;
        logic [OW-1:0] held;
        bit            have;

        bus.Conv_data_in       = '0;
        bus.Conv_data_valid_in = 1'b0;
        bus.flush_in           = 1'b0;
        bus.DDR_ready_in       = 1'b1;

        // Reset state
        #12;
        chk("rst_ddr_valid", OW'(bus.DDR_valid_out), OW'(0));
        chk("rst_ddr_data",  bus.DDR_data_out, OW'(0));
        chk("rst_flush_done", OW'(bus.flush_done), OW'(0));
        chk("rst_word_cnt",  OW'(bus.word_cnt), OW'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready_after", OW'(bus.Conv_ready_out), OW'(1));
        tick();

        // First-word latency: beats in cycles 0 and 1, word valid in cycle 3
        bus.Conv_data_in = rnd_beat();
        bus.Conv_data_valid_in = 1'b1;
        @(negedge clk);
        chk("lat_ready_c0", OW'(bus.Conv_ready_out), OW'(1));
        tick();
        bus.Conv_data_in = rnd_beat();
        @(negedge clk);
        chk("lat_ready_c1", OW'(bus.Conv_ready_out), OW'(1));
        tick();
        bus.Conv_data_valid_in = 1'b0;
        @(negedge clk);
        chk("lat_valid_c2", OW'(bus.DDR_valid_out), OW'(0));
        tick();
        @(negedge clk);
        chk("lat_valid_c3", OW'(bus.DDR_valid_out), OW'(1));
        tick();
        pulse_flush();
        wait_flush("lat_flush_done", lat);
        chk("lat_word_cnt_cleared", OW'(bus.word_cnt), OW'(0));

        // Sustained stream, byte pattern = beat index
        stall_cycles = 0;
        got_words.delete();
        for (int i = 0; i < 16; i++) send_beat(pat(i));
        repeat (5) tick();
        chk("sus_no_stall", OW'(stall_cycles), OW'(0));
        chk("sus_words", OW'(got_words.size()), OW'(9));
        w = got_words[0];
        chk("sus_word0", w, {{14{8'h01}}, {18{8'h00}}});
        w = got_words[8];
        chk("sus_word8_top", OW'(w[255:112]), OW'({18{8'h0f}}));
        chk("sus_word_cnt", OW'(bus.word_cnt), OW'(9));
        chk("sus_fill_empty", OW'(model_q.size()), OW'(0));

        // Backpressure: 10 stalled cycles mid-stream
        fork
            begin
                for (int i = 0; i < 12; i++) send_beat(rnd_beat());
            end
            begin
                repeat (3) @(posedge clk);
                ddr_mode = 2;
                have = 0;
                held = '0;
                repeat (10) begin
                    @(posedge clk);
                    #2;
                    if (bus.DDR_valid_out) begin
                        if (!have) begin
                            held = bus.DDR_data_out;
                            have = 1;
                        end else begin
                            chk("bp_data_held", bus.DDR_data_out, held);
                        end
                    end
                    chk("bp_ready", OW'(bus.Conv_ready_out),
                        OW'((model_q.size() - (bus.DDR_valid_out ? OW : 0)) < OW));
                end
                ddr_mode = 0;
            end
        join
        repeat (4) tick();
        pulse_flush();
        wait_flush("bp_flush_done", lat);
        chk("bp_drained", OW'(model_q.size()), OW'(0));
        chk("bp_word_cnt", OW'(bus.word_cnt), OW'(0));

        // Partial flush: 432 bits -> one full word, one padded word
        got_words.delete();
        for (int i = 0; i < 3; i++) send_beat(rnd_beat());
        pulse_flush();
        wait_flush("pf_flush_done", lat);
        chk("pf_words", OW'(got_words.size()), OW'(2));
        w = got_words[1];
        chk("pf_pad_zero", OW'(w[255:176]), OW'(0));
        chk("pf_word_cnt", OW'(bus.word_cnt), OW'(0));

        // Empty flush
        got_words.delete();
        vld0 = vld_cycles;
        pulse_flush();
        wait_flush("ef_flush_done", lat);
        chk("ef_latency_ok", OW'(lat <= 3), OW'(1));
        chk("ef_no_valid", OW'(vld_cycles - vld0), OW'(0));
        chk("ef_no_words", OW'(got_words.size()), OW'(0));

        // Flush coincident with a beat; ready low while flushing
        got_words.delete();
        send_beat(rnd_beat());
        bus.Conv_data_in       = rnd_beat();
        bus.Conv_data_valid_in = 1'b1;
        bus.flush_in           = 1'b1;
        flush_pend             = 1;
        @(negedge clk);
        chk("co_ready_at_flush", OW'(bus.Conv_ready_out), OW'(1));
        tick();
        bus.flush_in     = 1'b0;
        bus.Conv_data_in = rnd_beat();
        @(negedge clk);
        chk("co_ready_low_in_flush", OW'(bus.Conv_ready_out), OW'(0));
        tick();
        bus.Conv_data_valid_in = 1'b0;
        wait_flush("co_flush_done", lat);
        chk("co_words", OW'(got_words.size()), OW'(2));

        // Random beats, random DDR readiness, periodic flushes
        ddr_mode = 1;
        for (int i = 0; i < 40; i++) begin
            send_beat(rnd_beat());
            repeat ($urandom_range(0, 2)) tick();
            if ((i % 13) == 12) begin
                pulse_flush();
                wait_flush("rnd_flush_done", lat);
            end
        end
        pulse_flush();
        wait_flush("rnd_final_flush", lat);
        chk("rnd_drained", OW'(model_q.size()), OW'(0));
        chk("rnd_word_cnt", OW'(bus.word_cnt), OW'(0));

        // Async reset with a word pending
        ddr_mode = 0;
        for (int i = 0; i < 5; i++) send_beat(rnd_beat());
        repeat (3) tick();
        ddr_mode = 2;
        tick();
        send_beat(rnd_beat());
        repeat (3) tick();
        chk("ar_pre_valid", OW'(bus.DDR_valid_out), OW'(1));
        chk("ar_pre_word_cnt", OW'(bus.word_cnt), OW'(model_cnt));
        #2;
        rst = 1'b1;
        #1;
        chk("ar_valid_zero", OW'(bus.DDR_valid_out), OW'(0));
        chk("ar_data_zero", bus.DDR_data_out, OW'(0));
        chk("ar_word_cnt_zero", OW'(bus.word_cnt), OW'(0));
        chk("ar_flush_done_zero", OW'(bus.flush_done), OW'(0));
        model_q.delete();
        model_cnt  = 0;
        flush_pend = 0;
        got_words.delete();
        tick();
        rst      = 1'b0;
        ddr_mode = 0;
        tick();
        send_beat(rnd_beat());
        send_beat(rnd_beat());
        pulse_flush();
        wait_flush("ar_flush_done", lat);
        chk("ar_words_after", OW'(got_words.size()), OW'(2));
        chk("ar_drained", OW'(model_q.size()), OW'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, compared %0d mismatched %0d", n_cmp, n_bad);
        $fatal(1, "watchdog expired");
    end

endmodule
